// File: rtl/tx_pacer_pkg.sv
// ---------------------------------------------------------------------------
// tx_pacer_pkg
//   Shared definitions for the TX FIFO read-side pacer.
//   - txp_state_e     : pacer FSM state encodings (TXP_IDLE/TXP_GAP/TXP_STALL)
//   - FLOW_ID_W       : system flow-ID width
//   - FLOW_ID_NONE    : value shown on tx_fid_out before anything is issued
//   - TXP_MAX_CREDIT  : default downstream credit pool size
// ---------------------------------------------------------------------------
package tx_pacer_pkg;

    typedef enum logic [1:0] {
        TXP_IDLE  = 2'd0,
        TXP_GAP   = 2'd1,
        TXP_STALL = 2'd2
    } txp_state_e;

    localparam int FLOW_ID_W = 9;

    // All-ones is never handed out as a real flow ID.
    localparam logic [FLOW_ID_W-1:0] FLOW_ID_NONE = '1;

    localparam int TXP_MAX_CREDIT = 32;

endpackage

// File: rtl/tx_pacer_credit.sv
// ---------------------------------------------------------------------------
// tx_credit_cnt
//   Saturating up/down credit counter with a sticky overflow flag.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : one credit returned this cycle
//     dec        : one credit consumed this cycle (caller guarantees cnt != 0)
//     cnt        : current credit count, resets to MAX_CREDIT
//     ovf        : sticky, set when inc arrives alone while cnt == MAX_CREDIT
// ---------------------------------------------------------------------------
module tx_credit_cnt #(
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] cnt,
    output logic                ovf
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= MAX_C;
            ovf <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    // A return with the pool already full is dropped and flagged.
                    if (cnt == MAX_C) ovf <= 1'b1;
                    else              cnt <= cnt + ONE;
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - ONE;
                end
                default: ; // none, or a return and a consume that cancel out
            endcase
        end
    end

endmodule

// File: rtl/tx_pacer.sv
// ---------------------------------------------------------------------------
// tx_pacer
//   Read-side controller of the transmit flow-ID FIFO. Pops one flow ID when
//   issue is enabled, the FIFO is non-empty, a downstream credit is available
//   and the programmed inter-issue gap has elapsed; forwards the popped ID to
//   the network interface one cycle later.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     cfg_en            : issue enable (blocks new issues only)
//     cfg_gap           : idle cycles enforced after each issue (0 = back-to-back)
//     fifo_data_avail   : FIFO non-empty
//     fifo_r_data       : FIFO head flow ID
//     tx_val            : FIFO pop strobe, combinational, one cycle per issue
//     tx_fid_out        : issued flow ID, registered
//     tx_fid_val        : tx_fid_out valid, registered
//     dn_credit_ret     : one credit returned by the NI
//     credit_cnt        : current credits
//     credit_ovf        : sticky credit return overflow
//     busy              : FSM not in IDLE
//   Optional build macro TX_PACER_STATS_EN adds:
//     stat_issue_cnt    : wrapping count of issues
//     stat_stall_cyc    : wrapping count of cycles spent in STALL
// ---------------------------------------------------------------------------
module tx_pacer
    import tx_pacer_pkg::*;
#(
    parameter int FID_W      = FLOW_ID_W,
    parameter int GAP_W      = 8,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = TXP_MAX_CREDIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic                fifo_data_avail,
    input  logic [FID_W-1:0]    fifo_r_data,
    output logic                tx_val,
    output logic [FID_W-1:0]    tx_fid_out,
    output logic                tx_fid_val,
    input  logic                dn_credit_ret,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_ovf,
`ifdef TX_PACER_STATS_EN
    output logic [31:0]         stat_issue_cnt,
    output logic [31:0]         stat_stall_cyc,
`endif
    output logic                busy
);

    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    txp_state_e       state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             elig;
    logic             issue;

    assign elig = cfg_en & fifo_data_avail & (credit_cnt != '0);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        case (state_q)
            TXP_IDLE: begin
                if (elig) begin
                    issue = 1'b1;
                    if (cfg_gap != '0) begin
                        gap_d   = cfg_gap;
                        state_d = TXP_GAP;
                    end
                end else if (cfg_en && fifo_data_avail) begin
                    // Work is pending and enabled, so the only blocker is credit.
                    state_d = TXP_STALL;
                end
            end
            TXP_GAP: begin
                // Counts down from the value latched at issue; cfg changes
                // and cfg_en do not shorten or extend a running gap.
                gap_d = gap_q - GAP_ONE;
                if (gap_q <= GAP_ONE) state_d = TXP_IDLE;
            end
            TXP_STALL: begin
                if ((credit_cnt != '0) || !cfg_en) state_d = TXP_IDLE;
            end
            default: state_d = TXP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TXP_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Issue boundary: popped ID becomes visible one cycle after tx_val.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_fid_out <= FID_W'(FLOW_ID_NONE);
            tx_fid_val <= 1'b0;
        end else begin
            tx_fid_val <= issue;
            if (issue) tx_fid_out <= fifo_r_data;
        end
    end

    assign tx_val = issue;
    assign busy   = (state_q != TXP_IDLE);

    tx_credit_cnt #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dn_credit_ret),
        .dec   (issue),
        .cnt   (credit_cnt),
        .ovf   (credit_ovf)
    );

`ifdef TX_PACER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_cnt <= '0;
            stat_stall_cyc <= '0;
        end else begin
            if (issue)                  stat_issue_cnt <= stat_issue_cnt + 32'd1;
            if (state_q == TXP_STALL)   stat_stall_cyc <= stat_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_pacer.sv
// ---------------------------------------------------------------------------
// tb_tx_pacer
//   Directed self-checking bench for tx_pacer with a small queue standing in
//   for the TX FIFO. Each cycle begins 1 ns after the rising edge, where the
//   bench drives inputs; outputs are read 1 ns later.
// ---------------------------------------------------------------------------
module tb_tx_pacer;

    localparam int FID_W      = 9;
    localparam int GAP_W      = 8;
    localparam int CREDIT_W   = 6;
    localparam int MAX_CREDIT = 32;

    logic                clk;
    logic                rst_n;
    logic                cfg_en;
    logic [GAP_W-1:0]    cfg_gap;
    logic                fifo_data_avail;
    logic [FID_W-1:0]    fifo_r_data;
    logic                tx_val;
    logic [FID_W-1:0]    tx_fid_out;
    logic                tx_fid_val;
    logic                dn_credit_ret;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                credit_ovf;
    logic                busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [FID_W-1:0] q[$];

    tx_pacer #(
        .FID_W      (FID_W),
        .GAP_W      (GAP_W),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en          (cfg_en),
        .cfg_gap         (cfg_gap),
        .fifo_data_avail (fifo_data_avail),
        .fifo_r_data     (fifo_r_data),
        .tx_val          (tx_val),
        .tx_fid_out      (tx_fid_out),
        .tx_fid_val      (tx_fid_val),
        .dn_credit_ret   (dn_credit_ret),
        .credit_cnt      (credit_cnt),
        .credit_ovf      (credit_ovf),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic refresh();
        fifo_data_avail = (q.size() != 0);
        fifo_r_data     = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic peek();
        #1;
    endtask

    // Advance one cycle; pops the FIFO model if the pacer strobed tx_val.
    task automatic step();
        logic popped;
        @(negedge clk);
        popped = tx_val;
        @(posedge clk);
        #1;
        if (popped && q.size() != 0) void'(q.pop_front());
        refresh();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_en = 1'b0; cfg_gap = '0; dn_credit_ret = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #2;
        total_cnt++;
        if ({tx_val, tx_fid_val, busy, credit_ovf} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {tx_val, tx_fid_val, busy, credit_ovf});
        else pass_cnt++;
        total_cnt++;
        if (credit_cnt !== 6'd32) $display("FAIL reset_credit: got %0d want 32", credit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (tx_fid_out !== 9'h1FF) $display("FAIL reset_fid: got %h want 1ff", tx_fid_out);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_burst_gap();
        logic             exp_val, exp_fv;
        logic [FID_W-1:0] exp_id;
        cfg_en = 1'b1; cfg_gap = 8'd3;
        q.push_back(9'd5); q.push_back(9'd6); q.push_back(9'd7);
        refresh();
        for (int c = 0; c < 12; c++) begin
            peek();
            exp_val = (c == 0 || c == 4 || c == 8);
            exp_fv  = (c == 1 || c == 5 || c == 9);
            exp_id  = FID_W'(5 + (c - 1) / 4);
            total_cnt++;
            if (tx_val !== exp_val) $display("FAIL burst_tx_val c%0d: got %b want %b", c, tx_val, exp_val);
            else pass_cnt++;
            total_cnt++;
            if (tx_fid_val !== exp_fv) $display("FAIL burst_fid_val c%0d: got %b want %b", c, tx_fid_val, exp_fv);
            else pass_cnt++;
            if (exp_fv) begin
                total_cnt++;
                if (tx_fid_out !== exp_id) $display("FAIL burst_fid c%0d: got %0d want %0d", c, tx_fid_out, exp_id);
                else pass_cnt++;
            end
            step();
        end
        peek();
        total_cnt++;
        if ({busy, credit_cnt} !== {1'b0, 6'd29})
            $display("FAIL burst_end: got busy=%b cnt=%0d want busy=0 cnt=29", busy, credit_cnt);
        else pass_cnt++;
        dn_credit_ret = 1'b1;
        repeat (3) step();
        dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if ({credit_ovf, credit_cnt} !== {1'b0, 6'd32})
            $display("FAIL burst_refill: got ovf=%b cnt=%0d want ovf=0 cnt=32", credit_ovf, credit_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int issues;
        cfg_en = 1'b1; cfg_gap = 8'd0;
        for (int i = 0; i < 34; i++) q.push_back(FID_W'(100 + i));
        refresh();
        issues = 0;
        for (int c = 0; c < 36; c++) begin
            peek();
            if (tx_val) issues++;
            if (c >= 1 && c <= 32) begin
                total_cnt++;
                if ({tx_fid_val, tx_fid_out} !== {1'b1, FID_W'(99 + c)})
                    $display("FAIL b2b_fid c%0d: got v=%b id=%0d want v=1 id=%0d", c, tx_fid_val, tx_fid_out, 99 + c);
                else pass_cnt++;
            end
            step();
        end
        peek();
        total_cnt++;
        if (issues !== 32) $display("FAIL b2b_issues: got %0d want 32", issues);
        else pass_cnt++;
        total_cnt++;
        if ({credit_cnt, busy, tx_val} !== {6'd0, 1'b1, 1'b0})
            $display("FAIL b2b_stall: got cnt=%0d busy=%b tx_val=%b want 0 1 0", credit_cnt, busy, tx_val);
        else pass_cnt++;
        // one credit returns while stalled
        dn_credit_ret = 1'b1;
        step();
        dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if ({credit_cnt, tx_val} !== {6'd1, 1'b0})
            $display("FAIL stall_ret: got cnt=%0d tx_val=%b want cnt=1 tx_val=0", credit_cnt, tx_val);
        else pass_cnt++;
        step();
        peek();
        total_cnt++;
        if (tx_val !== 1'b1) $display("FAIL stall_resume: got tx_val=%b want 1", tx_val);
        else pass_cnt++;
        step();
        peek();
        total_cnt++;
        if ({tx_fid_val, tx_fid_out} !== {1'b1, 9'd132})
            $display("FAIL stall_fid: got v=%b id=%0d want v=1 id=132", tx_fid_val, tx_fid_out);
        else pass_cnt++;
        issues = 0;
        for (int c = 0; c < 4; c++) begin
            peek();
            if (tx_val) issues++;
            step();
        end
        peek();
        total_cnt++;
        if ({issues[3:0], credit_cnt, busy} !== {4'd0, 6'd0, 1'b1})
            $display("FAIL stall_again: got extra=%0d cnt=%0d busy=%b want 0 0 1", issues, credit_cnt, busy);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        cfg_en = 1'b0;
        dn_credit_ret = 1'b1;
        repeat (10) step();
        dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if ({credit_cnt, busy} !== {6'd10, 1'b0})
            $display("FAIL sim_setup: got cnt=%0d busy=%b want cnt=10 busy=0", credit_cnt, busy);
        else pass_cnt++;
        cfg_en = 1'b1; cfg_gap = 8'd0; dn_credit_ret = 1'b1;
        peek();
        total_cnt++;
        if (tx_val !== 1'b1) $display("FAIL sim_issue: got tx_val=%b want 1", tx_val);
        else pass_cnt++;
        step();
        cfg_en = 1'b0; dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if (credit_cnt !== 6'd10) $display("FAIL sim_credit: got %0d want 10", credit_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({tx_fid_val, tx_fid_out} !== {1'b1, 9'd133})
            $display("FAIL sim_fid: got v=%b id=%0d want v=1 id=133", tx_fid_val, tx_fid_out);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        int issues;
        cfg_en = 1'b0; cfg_gap = 8'd2;
        q.push_back(9'd200);
        refresh();
        issues = 0;
        for (int c = 0; c < 20; c++) begin
            peek();
            if (tx_val) issues++;
            step();
        end
        total_cnt++;
        if (issues !== 0) $display("FAIL en_block: got %0d issues want 0", issues);
        else pass_cnt++;
        cfg_en = 1'b1;
        peek();
        total_cnt++;
        if (tx_val !== 1'b1) $display("FAIL en_raise: got tx_val=%b want 1", tx_val);
        else pass_cnt++;
        step();
        cfg_en = 1'b0;
        q.push_back(9'd201);
        refresh();
        peek();
        total_cnt++;
        if ({busy, tx_fid_out} !== {1'b1, 9'd200})
            $display("FAIL en_gap1: got busy=%b id=%0d want busy=1 id=200", busy, tx_fid_out);
        else pass_cnt++;
        step();
        peek();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL en_gap2: got busy=%b want 1", busy);
        else pass_cnt++;
        step();
        peek();
        total_cnt++;
        if ({busy, tx_val, tx_fid_val} !== 3'b000)
            $display("FAIL en_gap_done: got %b want 000", {busy, tx_val, tx_fid_val});
        else pass_cnt++;
        step();
        peek();
        total_cnt++;
        if ({busy, tx_val, credit_cnt} !== {2'b00, 6'd9})
            $display("FAIL en_idle: got busy=%b tx_val=%b cnt=%0d want 0 0 9", busy, tx_val, credit_cnt);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        dn_credit_ret = 1'b1;
        repeat (23) step();
        dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if ({credit_ovf, credit_cnt} !== {1'b0, 6'd32})
            $display("FAIL ovf_full: got ovf=%b cnt=%0d want ovf=0 cnt=32", credit_ovf, credit_cnt);
        else pass_cnt++;
        dn_credit_ret = 1'b1;
        step();
        dn_credit_ret = 1'b0;
        peek();
        total_cnt++;
        if ({credit_ovf, credit_cnt} !== {1'b1, 6'd32})
            $display("FAIL ovf_set: got ovf=%b cnt=%0d want ovf=1 cnt=32", credit_ovf, credit_cnt);
        else pass_cnt++;
        repeat (3) step();
        peek();
        total_cnt++;
        if (credit_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", credit_ovf);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        cfg_en = 1'b1; cfg_gap = 8'd5;
        peek();
        total_cnt++;
        if (tx_val !== 1'b1) $display("FAIL rst_issue: got tx_val=%b want 1", tx_val);
        else pass_cnt++;
        repeat (4) step();
        peek();
        total_cnt++;
        if ({busy, credit_cnt} !== {1'b1, 6'd31})
            $display("FAIL rst_pre: got busy=%b cnt=%0d want busy=1 cnt=31", busy, credit_cnt);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({tx_val, tx_fid_val, busy, credit_ovf} !== 4'b0000)
            $display("FAIL rst_async_ctrl: got %b want 0000", {tx_val, tx_fid_val, busy, credit_ovf});
        else pass_cnt++;
        total_cnt++;
        if ({credit_cnt, tx_fid_out} !== {6'd32, 9'h1FF})
            $display("FAIL rst_async_data: got cnt=%0d id=%h want cnt=32 id=1ff", credit_cnt, tx_fid_out);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        peek();
        total_cnt++;
        if ({busy, tx_val} !== 2'b00) $display("FAIL rst_after: got %b want 00", {busy, tx_val});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_burst_gap();
        test_back_to_back();
        test_simultaneous();
        test_enable();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
